pipelined_cla_adder: RTL
========================

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and sum width; legal values are multiples of 8, from 8 to 64.
REQ-002 The block SHALL have parameter GROUP, default 8, giving the lookahead group width; it is fixed at 8, and other values are illegal.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- clock, input, 1 bit: the single clock; all state updates on its rising edge.
- reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Input-side ports SHALL be:
- in_valid, input, 1 bit: an operand set is presented.
- in_ready, output, 1 bit: the block can accept an operand set this cycle.
- op_a, input, WIDTH bits: operand A.
- op_b, input, WIDTH bits: operand B.
- cin, input, 1 bit: carry-in; used in add mode only.
- sub, input, 1 bit: 1 selects A-B, 0 selects A+B+cin.
REQ-005 Output-side ports SHALL be:
- out_valid, output, 1 bit: a result is presented.
- out_ready, input, 1 bit: downstream accepts the result this cycle.
- sum, output, WIDTH bits: the result.
- cout, output, 1 bit: carry out of the MSB.
- ovf, output, 1 bit: two's-complement signed overflow.
- zero, output, 1 bit: sum is all zeros.

Function
REQ-006 Effective operands SHALL be b_eff = sub ? ~op_b : op_b and c0 = sub ? 1 : cin.
REQ-007 Per-bit signals SHALL be g[i] = a[i] & b_eff[i] and p[i] = a[i] | b_eff[i].
REQ-008 Each 8-bit group SHALL also compute a group generate GG and a group propagate GP.
REQ-009 Stage 1 SHALL register a, b_eff, c0, p, g and every GG and GP, with valid flag s1_v.
REQ-010 Stage 2 SHALL do the following and register the result with valid flag s2_v:
- compute group carry-ins by lookahead across groups from the registered GG, GP and c0;
- compute in-group carries by full two-level lookahead (carry[k] = g[k] | p[k]g[k-1] | ... | p[k..0]c_grp);
- compute sum[i] = a[i] ^ b_eff[i] ^ c[i].
REQ-011 The registered outputs SHALL be: cout = carry out of bit WIDTH-1; ovf = carry into MSB XOR cout; zero = ~|sum.
REQ-012 The outputs sum, cout, ovf, zero and out_valid SHALL be driven directly from stage-2 registers, with no combinational path from op_a or op_b.
REQ-013 A transfer SHALL occur on a rising edge where valid and ready are both high; there is no other transfer.
REQ-014 Advance conditions SHALL be:
- adv2 = !s2_v | out_ready;
- adv1 = !s1_v | adv2;
- in_ready = adv1.
REQ-015 in_ready SHALL depend on no inputs other than out_ready and internal state.
REQ-016 Latency SHALL be exactly 2 cycles: an operand set accepted at edge k appears with out_valid=1 after edge k+1, when out_ready was high or s2 was empty at that edge.
REQ-017 Throughput SHALL be one result per cycle while out_ready=1.
REQ-018 While out_valid=1 and out_ready=0, sum, cout, ovf and zero SHALL hold stable.
REQ-019 Stage 1 SHALL fill during an output stall, and in_ready SHALL drop only when both stages are full.
REQ-020 Result order SHALL equal acceptance order; no result is dropped or duplicated.
REQ-021 When in_valid=0 and adv1=1, s1_v SHALL clear on the next edge.
REQ-022 When s2 is consumed with no s1 entry, out_valid SHALL clear on the next edge.
REQ-023 An accept and a consume in the same cycle with both stages full SHALL shift the pipeline without a bubble.
REQ-024 op_a, op_b, cin and sub are don't-care when in_valid=0; they SHALL NOT alter state.
REQ-025 Wrap-around: the sum SHALL be modulo 2^WIDTH, with the carry reported only via cout.

Reset
REQ-026 Asserting reset_n low SHALL immediately force s1_v=0, s2_v=0, out_valid=0, in_ready=1, sum=0, cout=0, ovf=0 and zero=0, independent of clock.
REQ-027 A reset asserted mid-operation SHALL discard all in-flight operand sets, which are never presented after reset.
REQ-028 The first acceptance SHALL occur no earlier than the first rising edge after reset_n deasserts.

Verification
REQ-029 Add, WIDTH=32: A=0xFFFFFFFF, B=0x00000001, cin=0, sub=0 -> 2 cycles later sum=0, cout=1, ovf=0, zero=1.
REQ-030 Signed overflow: A=0x7FFFFFFF, B=1, add -> sum=0x80000000, ovf=1, cout=0. Sub A=0x80000000, B=1 -> sum=0x7FFFFFFF, ovf=1, cout=1.
REQ-031 Full cross-group carry chain: A=0x00FFFFFF, B=0, cin=1 -> sum=0x01000000, cout=0. Sub A=5, B=5 -> sum=0, zero=1, cout=1.
REQ-032 Backpressure: stream 4 operand sets (i+1 for i=0..3, B=1) with out_ready low for 3 cycles -> in_ready falls after 2 accepts; on release, sums 2,3,4,5 arrive in order, back-to-back, stable while stalled.
REQ-033 Reset while both stages hold valid data -> out_valid=0 and in_ready=1 immediately; after release no stale result appears; a new A=3, B=4 yields 7.
REQ-034 Random: 10^5 random A, B, cin and sub with random valid/ready, at WIDTH 8, 32 and 64 -> every result matches a reference model, with order preserved.

Source files
------------

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// The master side presents operands and accepts results; the slave side is the adder.
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, op_a, op_b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, op_a, op_b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Two-stage carry-lookahead adder/subtractor with valid/ready flow control.
// Stage 1 registers per-bit and per-group generate/propagate; stage 2 resolves carries and the sum.
module pipelined_cla_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 8
) (
  input logic                  clock,
  input logic                  reset_n,
  pipelined_cla_adder_if.slave bus
);
  localparam int NG = WIDTH / GROUP;

  if (GROUP != 8 || WIDTH < 8 || WIDTH > 64 || (WIDTH % 8) != 0) begin : g_param_check
    $error("pipelined_cla_adder: unsupported WIDTH/GROUP combination");
  end

  // Two-level lookahead: carry into position k of a GROUP-wide slice, i.e.
  // g[k-1] | p[k-1]g[k-2] | ... | p[k-1..0]ci, with k = GROUP giving the slice carry-out.
  function automatic logic carry_at(input logic [GROUP-1:0] gi,
                                    input logic [GROUP-1:0] pi,
                                    input logic             ci,
                                    input int               k);
    logic c;
    logic t;
    c = ci;
    for (int m = 0; m < GROUP; m++)
      if (m < k) c = c & pi[m];
    for (int j = 0; j < GROUP; j++) begin
      if (j < k) begin
        t = gi[j];
        for (int m = 0; m < GROUP; m++)
          if (m > j && m < k) t = t & pi[m];
        c = c | t;
      end
    end
    return c;
  endfunction

  logic adv1, adv2, in_fire, out_load;
  logic vld_p1, vld_p2;

  logic [WIDTH-1:0] b_eff, g, p;
  logic             c0;
  logic [NG-1:0]    gg, gp;

  logic [WIDTH-1:0] a_p1, b_p1, g_p1, p_p1;
  logic             c0_p1;
  logic [NG-1:0]    gg_p1, gp_p1;

  logic [GROUP-1:0] ggx, gpx;
  logic [NG:0]      cgrp;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d, ovf_d, zero_d;

  logic [WIDTH-1:0] sum_p2;
  logic             cout_p2, ovf_p2, zero_p2;

  assign adv2     = !vld_p2 || bus.out_ready;
  assign adv1     = !vld_p1 || adv2;
  assign in_fire  = bus.in_valid && adv1;
  assign out_load = adv2 && vld_p1;

  // Stage 0: operand conditioning and generate/propagate
  always_comb begin
    b_eff = bus.sub ? ~bus.op_b : bus.op_b;
    c0    = bus.sub | bus.cin;
    g     = bus.op_a & b_eff;
    p     = bus.op_a | b_eff;
    gg    = '0;
    gp    = '0;
    for (int j = 0; j < NG; j++) begin
      gg[j] = carry_at(g[j*GROUP +: GROUP], p[j*GROUP +: GROUP], 1'b0, GROUP);
      gp[j] = &p[j*GROUP +: GROUP];
    end
  end

  // Stage 1 boundary: captured only on an accepted operand set
  always_ff @(posedge clock) begin
    if (in_fire) begin
      a_p1  <= bus.op_a;
      b_p1  <= b_eff;
      c0_p1 <= c0;
      g_p1  <= g;
      p_p1  <= p;
      gg_p1 <= gg;
      gp_p1 <= gp;
    end
  end

  // Stage 2: group carry lookahead, in-group carries, sum and flags
  always_comb begin
    ggx = '0;
    gpx = '0;
    ggx[NG-1:0] = gg_p1;
    gpx[NG-1:0] = gp_p1;
    cgrp  = '0;
    carry = '0;
    for (int j = 0; j <= NG; j++)
      cgrp[j] = carry_at(ggx, gpx, c0_p1, j);
    for (int j = 0; j < NG; j++)
      for (int k = 0; k < GROUP; k++)
        carry[j*GROUP + k] = carry_at(g_p1[j*GROUP +: GROUP], p_p1[j*GROUP +: GROUP],
                                      cgrp[j], k);
    sum_d  = a_p1 ^ b_p1 ^ carry;
    cout_d = cgrp[NG];
    ovf_d  = carry[WIDTH-1] ^ cout_d;
    zero_d = ~|sum_d;
  end

  // Stage 2 boundary: result registers drive the outputs directly
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum_p2  <= '0;
      cout_p2 <= 1'b0;
      ovf_p2  <= 1'b0;
      zero_p2 <= 1'b0;
    end else if (out_load) begin
      sum_p2  <= sum_d;
      cout_p2 <= cout_d;
      ovf_p2  <= ovf_d;
      zero_p2 <= zero_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (adv1) vld_p1 <= bus.in_valid;
      if (adv2) vld_p2 <= vld_p1;
    end
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = vld_p2;
  assign bus.sum       = sum_p2;
  assign bus.cout      = cout_p2;
  assign bus.ovf       = ovf_p2;
  assign bus.zero      = zero_p2;
endmodule
